// File: rtl/free_list_bank_pkg.sv
// free_list_bank_pkg: core sizing constants, PR tag type and reset tag helper for the free-list banks
package free_list_bank_pkg;
  localparam int LOG_PR_COUNT = 7;
  localparam int PRF_BANK_COUNT = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int AR_COUNT = 32;
  localparam int FREE_LIST_LENGTH_PER_BANK = 32;
  localparam int LOG_FREE_LIST_LENGTH_PER_BANK = 5;
  localparam int FREE_LIST_LOWER_THRESHOLD = 8;
  localparam int FREE_LIST_UPPER_THRESHOLD = 24;
  localparam int FREE_LIST_INIT_PER_BANK = FREE_LIST_LENGTH_PER_BANK - AR_COUNT / PRF_BANK_COUNT;
  typedef logic [LOG_PR_COUNT-1:0] pr_t;
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] fl_ptr_t;
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] fl_count_t;
  // Reset slot j holds the j-th PR of this bank above the ones mapped by architectural registers.
  function automatic pr_t init_pr(int bank, int j);
    return pr_t'((AR_COUNT / PRF_BANK_COUNT + j) * PRF_BANK_COUNT + bank);
  endfunction
endpackage

// File: rtl/free_list_bank_if.sv
// free_list_bank_if: enqueue (commit), dequeue (rename) and occupancy signals of one free-list bank
interface free_list_bank_if;
  import free_list_bank_pkg::*;
  logic enq_valid;
  pr_t enq_pr;
  logic enq_ready;
  logic deq_valid;
  pr_t deq_pr;
  logic deq_ready;
  fl_count_t count;
  logic below_lower;
  logic above_upper;
  modport master (
    output enq_valid, enq_pr, deq_ready,
    input enq_ready, deq_valid, deq_pr, count, below_lower, above_upper
  );
  modport slave (
    input enq_valid, enq_pr, deq_ready,
    output enq_ready, deq_valid, deq_pr, count, below_lower, above_upper
  );
endinterface

// File: rtl/free_list_bank.sv
// free_list_bank: circular FIFO of free PR tags for one bank, preloaded at reset, with occupancy thresholds
module free_list_bank
  import free_list_bank_pkg::*;
#(
  parameter int BANK_ID = 0,
  parameter int LOWER_THRESHOLD = FREE_LIST_LOWER_THRESHOLD,
  parameter int UPPER_THRESHOLD = FREE_LIST_UPPER_THRESHOLD
) (
  input logic clk,
  input logic rst,
  free_list_bank_if.slave bus
);
  localparam int DEPTH = FREE_LIST_LENGTH_PER_BANK;
  localparam int CW = LOG_FREE_LIST_LENGTH_PER_BANK + 1;
  localparam int PW = LOG_FREE_LIST_LENGTH_PER_BANK;
  pr_t r_mem [DEPTH];
  fl_ptr_t r_head;
  fl_ptr_t r_tail;
  fl_count_t r_count;
  logic w_enq_fire;
  logic w_deq_fire;
  // Full/empty come from the registered count only, so there is no enq/deq bypass.
  always_comb begin
    bus.enq_ready = r_count != CW'(DEPTH);
    bus.deq_valid = r_count != '0;
    bus.deq_pr = r_mem[r_head];
    bus.count = r_count;
    bus.below_lower = r_count < CW'(LOWER_THRESHOLD);
    bus.above_upper = r_count > CW'(UPPER_THRESHOLD);
    w_enq_fire = bus.enq_valid & bus.enq_ready;
    w_deq_fire = bus.deq_valid & bus.deq_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++)
        r_mem[j] <= j < FREE_LIST_INIT_PER_BANK ? init_pr(BANK_ID, j) : '0;
      r_head <= '0;
      r_tail <= PW'(FREE_LIST_INIT_PER_BANK);
      r_count <= CW'(FREE_LIST_INIT_PER_BANK);
    end else begin
      if (w_enq_fire) r_mem[r_tail] <= bus.enq_pr;
      r_tail <= w_enq_fire ? r_tail + PW'(1) : r_tail;
      r_head <= w_deq_fire ? r_head + PW'(1) : r_head;
      r_count <= r_count + CW'(w_enq_fire) - CW'(w_deq_fire);
    end
  end
  // PRs are conserved, so a push toward a full bank means the commit path has lost track.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!w_enq_fire || bus.enq_pr[LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(BANK_ID))
        else $error("free_list_bank: enqueued PR %0d does not belong to bank %0d", bus.enq_pr, BANK_ID);
      assert (!(bus.enq_valid && r_count == CW'(DEPTH)))
        else $warning("free_list_bank: enq_valid while bank %0d is full", BANK_ID);
      assert (!(bus.deq_ready && !bus.deq_valid))
        else $error("free_list_bank: deq_ready while bank %0d is empty", BANK_ID);
    end
  end
endmodule

// File: tb/tb_free_list_bank.sv
// tb_free_list_bank: directed tests for bank 1 checked against a queue model every cycle plus literal expectations
module tb_free_list_bank;
  import free_list_bank_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  int mdl[$];
  bit mdl_ok = 0;
  free_list_bank_if fl ();
  free_list_bank #(.BANK_ID(1)) dut (.clk(clk), .rst(rst), .bus(fl));
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: queue of free tags; reset reloads PRs 33,37,...,125, pushes ignored when 32 held.
  always @(posedge clk) begin
    if (rst) begin
      mdl.delete();
      for (int j = 0; j < 24; j++) mdl.push_back(32 + 4 * j + 1);
      mdl_ok = 1;
    end else if (mdl_ok) begin
      bit e, d;
      e = fl.enq_valid && mdl.size() != 32;
      d = fl.deq_ready && mdl.size() != 0;
      if (d) void'(mdl.pop_front());
      if (e) mdl.push_back(int'(fl.enq_pr));
    end
  end
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("m_count", int'(fl.count), mdl.size());
      chk("m_deq_valid", int'(fl.deq_valid), int'(mdl.size() != 0));
      chk("m_enq_ready", int'(fl.enq_ready), int'(mdl.size() != 32));
      chk("m_below", int'(fl.below_lower), int'(mdl.size() < 8));
      chk("m_above", int'(fl.above_upper), int'(mdl.size() > 24));
      if (mdl.size() != 0) chk("m_deq_pr", int'(fl.deq_pr), mdl[0]);
    end
  end
  task automatic cyc(bit r, bit ev, int epr, bit dr);
    rst = r;
    fl.enq_valid = ev;
    fl.enq_pr = pr_t'(epr);
    fl.deq_ready = dr;
    @(negedge clk);
  endtask
  task automatic chk_reset_state(string tag);
    chk({tag, "_deq_valid"}, int'(fl.deq_valid), 1);
    chk({tag, "_deq_pr"}, int'(fl.deq_pr), 33);
    chk({tag, "_count"}, int'(fl.count), 24);
    chk({tag, "_enq_ready"}, int'(fl.enq_ready), 1);
    chk({tag, "_below"}, int'(fl.below_lower), 0);
    chk({tag, "_above"}, int'(fl.above_upper), 0);
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_reset_state("t1");
    for (int k = 0; k < 17; k++) begin
      chk("t2_pop_pr", int'(fl.deq_pr), 33 + 4 * k);
      cyc(0, 0, 0, 1);
    end
    chk("t2_count7", int'(fl.count), 7);
    chk("t2_below7", int'(fl.below_lower), 1);
    for (int k = 17; k < 24; k++) begin
      chk("t2_pop_pr", int'(fl.deq_pr), 33 + 4 * k);
      cyc(0, 0, 0, 1);
    end
    cyc(0, 0, 0, 0);
    chk("t2_empty_valid", int'(fl.deq_valid), 0);
    chk("t2_empty_count", int'(fl.count), 0);
    chk("t3_before_valid", int'(fl.deq_valid), 0);
    cyc(0, 1, 5, 0);
    chk("t3_after_valid", int'(fl.deq_valid), 1);
    chk("t3_after_pr", int'(fl.deq_pr), 5);
    chk("t3_after_count", int'(fl.count), 1);
    cyc(0, 0, 0, 1);
    chk("t3_drain_valid", int'(fl.deq_valid), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1 + 4 * i, 0);
      chk("t4_count", int'(fl.count), 25 + i);
      chk("t4_above", int'(fl.above_upper), 1);
    end
    chk("t4_full_ready", int'(fl.enq_ready), 0);
    cyc(0, 1, 33, 1);
    chk("t4_refused_count", int'(fl.count), 31);
    chk("t4_refused_pr", int'(fl.deq_pr), 37);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, 1, (4 * i + 1) % 128, 1);
    cyc(0, 0, 0, 0);
    chk("t5_count", int'(fl.count), 24);
    chk("t5_head_pr", int'(fl.deq_pr), (4 * 76 + 1) % 128);
    cyc(0, 1, 9, 1);
    cyc(0, 1, 13, 0);
    cyc(1, 1, 17, 1);
    chk_reset_state("t6");
    cyc(0, 0, 0, 0);
    chk_reset_state("t6_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
